// File: rtl/logic_analyzer.sv
// rtl/logic_analyzer.sv - pre/post-trigger sample capture engine
// Circular sample buffer with programmable trigger and frozen DEPTH-sample window.
module logic_analyzer #(
  parameter int DEPTH = 8,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sample_en,
  input  logic [7:0]         probe,
  input  logic               trig_ext,
  input  logic               arm,
  input  logic               abort,
  input  logic [1:0]         trig_mode,
  input  logic [7:0]         trig_pattern,
  input  logic [7:0]         trig_mask,
  input  logic [PW-1:0]      pretrig,
  output logic               is_analyzer_run,
  output logic               is_analyzer_lock,
  output logic [DEPTH*8-1:0] capture_flat
);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, LOCKED} state_t;

  state_t        state, state_nxt;
  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] fill;
  logic [PW-1:0] post;
  logic          trig_prev;

  logic          trig_hit;
  logic          arm_start;
  logic          do_write;
  logic          accept;
  logic [PW-1:0] post_init;

  assign post_init = PW'(DEPTH - 1) - pretrig;

  always_comb begin
    case (trig_mode)
      2'b00:   trig_hit = 1'b1;
      2'b01:   trig_hit = trig_ext & ~trig_prev;
      2'b10:   trig_hit = ~trig_ext & trig_prev;
      default: trig_hit = ((probe ^ trig_pattern) & trig_mask) == 8'h00;
    endcase
  end

  always_comb begin
    state_nxt = state;
    arm_start = 1'b0;
    do_write  = 1'b0;
    accept    = 1'b0;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, LOCKED: begin
          if (arm) begin
            arm_start = 1'b1;
            state_nxt = ARMED;
          end
        end
        ARMED: begin
          if (sample_en) begin
            do_write = 1'b1;
            // A trigger only counts once the full pretrigger history is in the buffer.
            if (trig_hit && (fill == pretrig)) begin
              accept    = 1'b1;
              state_nxt = (post_init == '0) ? LOCKED : CAPTURE;
            end
          end
        end
        CAPTURE: begin
          if (sample_en) begin
            do_write = 1'b1;
            if (post <= PW'(1)) state_nxt = LOCKED;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      wptr             <= '0;
      fill             <= '0;
      post             <= '0;
      trig_prev        <= 1'b0;
      is_analyzer_run  <= 1'b0;
      is_analyzer_lock <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
    end else begin
      state            <= state_nxt;
      is_analyzer_run  <= (state_nxt == ARMED) || (state_nxt == CAPTURE);
      is_analyzer_lock <= (state_nxt == LOCKED);
      if (arm_start) begin
        wptr      <= '0;
        fill      <= '0;
        trig_prev <= trig_ext;
      end
      if (do_write) begin
        mem[wptr] <= probe;
        wptr      <= wptr + PW'(1);
        if (state == ARMED) begin
          trig_prev <= trig_ext;
          if (fill < pretrig) fill <= fill + PW'(1);
        end
      end
      if (accept) post <= post_init;
      else if (do_write && (state == CAPTURE)) post <= post - PW'(1);
    end
  end

  // Oldest sample first: once locked, wptr sits on the oldest entry.
  for (genvar k = 0; k < DEPTH; k++) begin : g_flat
    assign capture_flat[k*8 +: 8] = mem[wptr + PW'(k)];
  end

endmodule

// File: tb/tb_logic_analyzer.sv
// tb/tb_logic_analyzer.sv - self-checking bench for logic_analyzer
// Table-driven capture scenarios plus hand sequences for abort and reset.
module tb_logic_analyzer;
  localparam int DEPTH = 8;
  localparam int PW    = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic               sample_en;
  logic [7:0]         probe;
  logic               trig_ext;
  logic               arm;
  logic               abort;
  logic [1:0]         trig_mode;
  logic [7:0]         trig_pattern;
  logic [7:0]         trig_mask;
  logic [PW-1:0]      pretrig;
  logic               is_analyzer_run;
  logic               is_analyzer_lock;
  logic [DEPTH*8-1:0] capture_flat;

  always #5 clk = ~clk;

  logic_analyzer #(.DEPTH(DEPTH), .PW(PW)) dut (
    .clk              (clk),
    .rst              (rst),
    .sample_en        (sample_en),
    .probe            (probe),
    .trig_ext         (trig_ext),
    .arm              (arm),
    .abort            (abort),
    .trig_mode        (trig_mode),
    .trig_pattern     (trig_pattern),
    .trig_mask        (trig_mask),
    .pretrig          (pretrig),
    .is_analyzer_run  (is_analyzer_run),
    .is_analyzer_lock (is_analyzer_lock),
    .capture_flat     (capture_flat)
  );

  typedef struct {
    logic [1:0]    mode;
    logic [PW-1:0] pre;
    logic [7:0]    pat;
    logic [7:0]    mask;
    int            div;
    int            trig_at;
    logic [7:0]    base;
    int            exp_n;
    logic [7:0]    exp_trig;
  } vec_t;

  vec_t       vecs [6];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] sb [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] probe_of(input vec_t v, input int i);
    if (v.mode == 2'b11) return (i == 2) ? 8'hA5 : (i == 9) ? 8'hAF : 8'h30 + 8'(i);
    return v.base + 8'(i);
  endfunction

  function automatic logic trig_of(input vec_t v, input int i);
    if (v.mode == 2'b01) return i >= v.trig_at;
    if (v.mode == 2'b10) return i < v.trig_at;
    return 1'b0;
  endfunction

  task automatic check_window(input string name);
    while (sb.size() > DEPTH) void'(sb.pop_front());
    for (int k = 0; k < DEPTH; k++) begin
      if (sb.size() == 0) check($sformatf("%s_sb_empty%0d", name, k), 1, 0);
      else check($sformatf("%s_byte%0d", name, k), capture_flat[k*8 +: 8], sb.pop_front());
    end
    sb.delete();
  endtask

  task automatic arm_cfg(input vec_t v, input string name);
    trig_mode    = v.mode;
    trig_pattern = v.pat;
    trig_mask    = v.mask;
    pretrig      = v.pre;
    sample_en    = 1'b0;
    trig_ext     = trig_of(v, 0);
    arm          = 1'b1;
    tick();
    arm = 1'b0;
    check({name, "_run_after_arm"}, is_analyzer_run, 1);
    check({name, "_lock_after_arm"}, is_analyzer_lock, 0);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int   i = 0;
    int   c = 0;
    logic locked = 1'b0;
    logic strobe_at_lock = 1'b0;
    logic run_drop = 1'b0;
    sb.delete();
    arm_cfg(v, name);
    while (!locked && c < 400) begin
      sample_en = ((c % v.div) == 0);
      if (sample_en) begin
        probe    = probe_of(v, i);
        trig_ext = trig_of(v, i);
        sb.push_back(probe);
        i++;
      end else begin
        probe = 8'hEE;
      end
      tick();
      c++;
      if (is_analyzer_lock) begin
        locked         = 1'b1;
        strobe_at_lock = sample_en;
      end else if (!is_analyzer_run) begin
        run_drop = 1'b1;
      end
    end
    check({name, "_locked"}, locked, 1);
    check({name, "_samples"}, i, v.exp_n);
    check({name, "_lock_on_strobe"}, strobe_at_lock, 1);
    check({name, "_run_stayed_high"}, run_drop, 0);
    // LOCKED must ignore further strobes
    sample_en = 1'b1;
    probe     = 8'hEE;
    repeat (3) tick();
    sample_en = 1'b0;
    check({name, "_run_locked"}, is_analyzer_run, 0);
    check({name, "_lock_held"}, is_analyzer_lock, 1);
    check({name, "_trig_byte"}, capture_flat[v.pre*8 +: 8], v.exp_trig);
    check_window(name);
  endtask

  initial begin
    vecs[0] = '{2'b00, 3'd0, 8'h00, 8'h00, 1, 0,  8'h10, 8,  8'h10};
    vecs[1] = '{2'b01, 3'd3, 8'h00, 8'h00, 1, 10, 8'h00, 15, 8'h0A};
    vecs[2] = '{2'b11, 3'd7, 8'hA0, 8'hF0, 1, 0,  8'h00, 10, 8'hAF};
    vecs[3] = '{2'b00, 3'd0, 8'h00, 8'h00, 4, 0,  8'h40, 8,  8'h40};
    vecs[4] = '{2'b10, 3'd5, 8'h00, 8'h00, 1, 6,  8'h80, 9,  8'h86};
    vecs[5] = '{2'b00, 3'd7, 8'h00, 8'h00, 2, 0,  8'h20, 8,  8'h27};

    rst = 1'b1; sample_en = 1'b0; probe = 8'h00; trig_ext = 1'b0; arm = 1'b0; abort = 1'b0;
    trig_mode = 2'b00; trig_pattern = 8'h00; trig_mask = 8'h00; pretrig = '0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check("reset_run", is_analyzer_run, 0);
    check("reset_lock", is_analyzer_lock, 0);
    check("reset_flat", capture_flat, 64'h0);

    for (int v = 0; v < 6; v++) run_vec(vecs[v], $sformatf("vec%0d", v));

    // Rising-edge mode with trig_ext already high never triggers; abort recovers.
    sb.delete();
    arm_cfg('{2'b01, 3'd0, 8'h00, 8'h00, 1, 0, 8'h00, 0, 8'h00}, "hold");
    trig_ext = 1'b1;
    for (int i = 0; i < 12; i++) begin
      sample_en = 1'b1;
      probe     = 8'h50 + 8'(i);
      sb.push_back(probe);
      tick();
    end
    sample_en = 1'b0;
    check("hold_run", is_analyzer_run, 1);
    check("hold_lock", is_analyzer_lock, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_run", is_analyzer_run, 0);
    check("abort_lock", is_analyzer_lock, 0);
    arm = 1'b1; abort = 1'b1;
    tick();
    arm = 1'b0; abort = 1'b0;
    check("arm_abort_run", is_analyzer_run, 0);
    check_window("abort_buf");
    trig_ext = 1'b0;

    // Reset in the middle of CAPTURE, then a normal run.
    arm_cfg(vecs[0], "midrst");
    sample_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      probe = 8'h70 + 8'(i);
      tick();
    end
    rst = 1'b1;
    sample_en = 1'b0;
    tick();
    check("midrst_run", is_analyzer_run, 0);
    check("midrst_lock", is_analyzer_lock, 0);
    check("midrst_flat", capture_flat, 64'h0);
    rst = 1'b0;
    tick();
    run_vec(vecs[0], "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
